// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and FSM encoding for the memory-mapped UART.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int STAT_TX_FULL    = 0;
    localparam int STAT_TX_EMPTY   = 1;
    localparam int STAT_RX_VALID   = 2;
    localparam int STAT_RX_OVERRUN = 3;

    localparam int MinDiv = 2;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with a one-bit-wider count so full and empty are unambiguous.
module uart_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    // A simultaneous pop frees the slot the push needs, so a full FIFO still accepts it.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_device.sv
// Memory-mapped 8N1 UART: TX FIFO + serializer, RX deserializer + holding register, baud divider, irq.
module uart_device
    import uart_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddrressWidth = 32,
    parameter int TxFifoDepth   = 8,
    parameter int DivWidth      = 16,
    parameter int DefaultDiv    = 434
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     device_req_i,
    input  logic [AddrressWidth-1:0] device_addr_i,
    input  logic                     device_we_i,
    input  logic [DataWidth-1:0]     device_wdata_i,
    output logic [DataWidth-1:0]     device_rdata_o,
    output logic                     uart_tx_o,
    input  logic                     uart_rx_i,
    output logic                     irq_o
);
    localparam int CntW = $clog2(TxFifoDepth) + 1;

    logic [1:0]          reg_sel;
    logic                rd_en, wr_en, unused_bus;
    logic [DivWidth-1:0] div_q;
    logic [DataWidth-1:0] rdata_d;

    assign reg_sel    = device_addr_i[3:2];
    assign rd_en      = device_req_i & ~device_we_i;
    assign wr_en      = device_req_i & device_we_i;
    assign unused_bus = ^{device_addr_i, device_wdata_i};

    // ---------------- TX ----------------
    logic            tx_push, tx_pop, tx_full, tx_fifo_empty, tx_empty;
    logic [7:0]      tx_head;
    logic [CntW-1:0] tx_count;

    assign tx_push = wr_en && (reg_sel == REG_TXDATA);

    uart_fifo #(.Width(8), .Depth(TxFifoDepth)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .wdata_i (device_wdata_i[7:0]),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_fifo_empty),
        .count_o (tx_count)
    );

    uart_state_e         tx_state_q, tx_state_d;
    logic [DivWidth-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]          tx_bit_q, tx_bit_d;
    logic [7:0]          tx_shift_q, tx_shift_d;
    logic                tx_tick;

    assign tx_tick  = (tx_cnt_q == '0);
    assign tx_empty = (tx_count == '0) && (tx_state_q == IDLE);

    // The bit timer reloads from div_q only at bit boundaries, so DIV writes land on the next bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? tx_cnt_q : tx_cnt_q - 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d = tx_cnt_q;
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = div_q - 1'b1;
                    tx_state_d = START;
                end
            end
            START: if (tx_tick) begin
                tx_state_d = DATA;
                tx_bit_d   = '0;
                tx_cnt_d   = div_q - 1'b1;
            end
            DATA: if (tx_tick) begin
                tx_cnt_d = div_q - 1'b1;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = STOP;
                end else begin
                    tx_bit_d   = tx_bit_q + 1'b1;
                    tx_shift_d = tx_shift_q >> 1;
                end
            end
            STOP: if (tx_tick) begin
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = div_q - 1'b1;
                    tx_state_d = START;
                end else begin
                    tx_state_d = IDLE;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (tx_state_q)
            START:   uart_tx_o = 1'b0;
            DATA:    uart_tx_o = tx_shift_q[0];
            default: uart_tx_o = 1'b1;
        endcase
    end

    // ---------------- RX ----------------
    logic [1:0]          rx_sync_q;
    logic                rx_prev_q, rx_s, rx_deliver, rx_pop;
    uart_state_e         rx_state_q, rx_state_d;
    logic [DivWidth-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]          rx_bit_q, rx_bit_d;
    logic [7:0]          rx_shift_q, rx_shift_d, rx_byte_q;
    logic                rx_valid_q, rx_ovr_q, rx_tick;

    assign rx_s    = rx_sync_q[1];
    assign rx_tick = (rx_cnt_q == '0);
    assign rx_pop  = rd_en && (reg_sel == REG_RXDATA) && rx_valid_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_tick ? rx_cnt_q : rx_cnt_q - 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_deliver = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d = rx_cnt_q;
                if (rx_prev_q && !rx_s) begin
                    rx_state_d = START;
                    rx_cnt_d   = (div_q >> 1) - 1'b1;
                end
            end
            START: if (rx_tick) begin
                rx_state_d = rx_s ? IDLE : DATA;
                rx_bit_d   = '0;
                rx_cnt_d   = div_q - 1'b1;
            end
            DATA: if (rx_tick) begin
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                rx_cnt_d   = div_q - 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = STOP;
                else                  rx_bit_d   = rx_bit_q + 1'b1;
            end
            STOP: if (rx_tick) begin
                rx_deliver = rx_s;
                rx_state_d = IDLE;
            end
            default: ;
        endcase
    end

    // ---------------- Registers ----------------
    always_comb begin
        rdata_d = '0;
        case (reg_sel)
            REG_RXDATA: begin
                rdata_d[DataWidth-1] = rx_valid_q;
                rdata_d[7:0]         = rx_byte_q;
            end
            REG_STATUS: begin
                rdata_d[STAT_TX_FULL]    = tx_full;
                rdata_d[STAT_TX_EMPTY]   = tx_empty;
                rdata_d[STAT_RX_VALID]   = rx_valid_q;
                rdata_d[STAT_RX_OVERRUN] = rx_ovr_q;
            end
            REG_DIV: rdata_d[DivWidth-1:0] = div_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_sync_q  <= {rx_sync_q[0], uart_rx_i};
            rx_prev_q  <= rx_s;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_q          <= DivWidth'(DefaultDiv);
            rx_byte_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_ovr_q       <= 1'b0;
            device_rdata_o <= '0;
            irq_o          <= 1'b0;
        end else begin
            if (wr_en && (reg_sel == REG_DIV))
                div_q <= (device_wdata_i[DivWidth-1:0] < DivWidth'(MinDiv)) ?
                         DivWidth'(MinDiv) : device_wdata_i[DivWidth-1:0];
            if (rd_en) device_rdata_o <= rdata_d;
            if (wr_en && (reg_sel == REG_STATUS) && device_wdata_i[STAT_RX_OVERRUN])
                rx_ovr_q <= 1'b0;
            // A pop clears the byte so a read of an empty RXDATA returns all zeros.
            if (rx_deliver) begin
                if (!rx_valid_q || rx_pop) begin
                    rx_byte_q  <= rx_shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_ovr_q <= 1'b1;
                end
            end else if (rx_pop) begin
                rx_valid_q <= 1'b0;
                rx_byte_q  <= '0;
            end
            irq_o <= rx_valid_q | rx_ovr_q;
        end
    end

endmodule

// File: tb/tb_uart_device.sv
// Scoreboard bench for uart_device: a serial decoder and a read monitor check against queued expectations.
`timescale 1ns/1ps
module tb_uart_device;

    localparam logic [1:0] A_TX = 2'd0, A_RX = 2'd1, A_ST = 2'd2, A_DIV = 2'd3;

    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0, rx = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        tx, irq;

    int          vectors = 0, miscompares = 0;
    longint      cyc = 0, last_start = 0;
    int          tb_div = 434;
    int          in_fifo;
    logic [7:0]  tx_exp_q [$];
    logic [31:0] rd_exp_q [$];
    string       rd_tag_q [$];
    logic [31:0] last_rd = '0;
    logic        contig_chk = 1'b0, prev_burst = 1'b0;
    logic        m_valid = 1'b0, m_ovr = 1'b0;
    logic [7:0]  m_byte = '0;

    uart_device #(.DataWidth(32), .AddrressWidth(32), .TxFifoDepth(8), .DivWidth(16),
                  .DefaultDiv(434)) dut (
        .clk_i(clk), .rst_ni(rst_n), .device_req_i(req), .device_addr_i(addr),
        .device_we_i(we), .device_wdata_i(wdata), .device_rdata_o(rdata),
        .uart_tx_o(tx), .uart_rx_i(rx), .irq_o(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: received-byte holding slot with overrun flag.
    function automatic logic [31:0] exp_status(input logic empty, input logic full);
        return {28'b0, m_ovr, m_valid, empty, full};
    endfunction

    task automatic m_deliver(input logic [7:0] b);
        if (m_valid) m_ovr = 1'b1;
        else begin m_valid = 1'b1; m_byte = b; end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = {28'h0, r, 2'b00}; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] r, input logic [31:0] e, input string tag);
        rd_exp_q.push_back(e); rd_tag_q.push_back(tag);
        req = 1'b1; we = 1'b0; addr = {28'h0, r, 2'b00};
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] e;
        e = {m_valid, 23'b0, m_byte};
        m_valid = 1'b0; m_byte = '0;
        bus_read(A_RX, e, tag);
    endtask

    task automatic write_div(input int d);
        bus_write(A_DIV, 32'(d));
        tb_div = (d < 2) ? 2 : d;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin rx = f[i]; idle(tb_div); end
        rx = 1'b1;
    endtask

    task automatic tx_drain();
        int n;
        n = 0;
        while (tx_exp_q.size() != 0 && n < 5000) begin @(negedge clk); n++; end
        chk("tx_drain_pending", 32'(tx_exp_q.size()), 32'd0);
        idle(2 * tb_div + 4);
    endtask

    task automatic mwait(input int n, inout logic ab);
        repeat (n) begin @(negedge clk); if (!rst_n) ab = 1'b1; end
    endtask

    // Serial decoder: samples each bit mid-period and pops the expected byte.
    initial begin : tx_mon
        logic [7:0] b;
        logic ab, stb, sp;
        int d;
        forever begin
            @(negedge clk);
            if (rst_n && !tx) begin
                d = tb_div; ab = 1'b0;
                if (contig_chk && prev_burst) chk("tx_gap", 32'(cyc - last_start), 32'(10 * d));
                prev_burst = contig_chk; last_start = cyc;
                mwait(d / 2, ab); stb = tx;
                for (int i = 0; i < 8; i++) begin mwait(d, ab); b[i] = tx; end
                mwait(d, ab); sp = tx;
                if (!ab) begin
                    chk("tx_frame_expected", 32'(tx_exp_q.size() != 0), 32'd1);
                    if (tx_exp_q.size() != 0)
                        chk("tx_frame", {22'b0, sp, b, stb}, {22'b0, 1'b1, tx_exp_q.pop_front(), 1'b0});
                end
            end
        end
    end

    // Read monitor: compares read data the cycle after a read; writes must leave it unchanged.
    initial begin : rd_mon
        logic [31:0] e;
        string t;
        forever begin
            @(posedge clk);
            if (!rst_n) last_rd = '0;
            else if (req && !we) begin
                @(negedge clk);
                chk("rd_expected", 32'(rd_exp_q.size() != 0), 32'd1);
                if (rd_exp_q.size() != 0) begin
                    e = rd_exp_q.pop_front(); t = rd_tag_q.pop_front();
                    chk(t, rdata, e);
                    last_rd = e;
                end
            end else if (req && we) begin
                @(negedge clk);
                chk("wr_hold_rdata", rdata, last_rd);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        bus_read(A_ST, exp_status(1'b1, 1'b0), "reset_status");
        bus_read(A_DIV, 32'd434, "reset_div");

        // Single frame
        write_div(4);
        tx_exp_q.push_back(8'hA5);
        bus_write(A_TX, 32'hA5);
        tx_drain();
        bus_read(A_ST, exp_status(1'b1, 1'b0), "status_after_tx");

        // FIFO fill: one byte in flight, eight queued, ninth dropped, all frames contiguous
        contig_chk = 1'b1;
        tx_exp_q.push_back(8'h00);
        bus_write(A_TX, 32'h00);
        idle(1);
        in_fifo = 0;
        for (int i = 1; i <= 9; i++) begin
            if (in_fifo < 8) begin tx_exp_q.push_back(8'(i)); in_fifo++; end
            bus_write(A_TX, 32'(i));
            if (i == 8) bus_read(A_ST, exp_status(1'b0, 1'b1), "status_full");
        end
        bus_read(A_ST, exp_status(1'b0, 1'b1), "status_full_after_drop");
        tx_drain();
        contig_chk = 1'b0;
        bus_read(A_ST, exp_status(1'b1, 1'b0), "status_after_burst");

        // Random TX bursts
        for (int r = 0; r < 3; r++) begin
            int n;
            logic [7:0] b;
            write_div($urandom_range(2, 6));
            n = $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                tx_exp_q.push_back(b);
                bus_write(A_TX, {24'h0, b});
            end
            tx_drain();
        end

        // RX with interrupt
        write_div(8);
        rx_frame(8'h3C, 1'b1); idle(tb_div + 6); m_deliver(8'h3C);
        chk("irq_rx", 32'(irq), 32'(m_valid | m_ovr));
        read_rx("rxdata_3c");
        idle(2);
        chk("irq_after_pop", 32'(irq), 32'(m_valid | m_ovr));
        read_rx("rxdata_empty");

        // Overrun
        rx_frame(8'h11, 1'b1); idle(tb_div + 6); m_deliver(8'h11);
        rx_frame(8'h22, 1'b1); idle(tb_div + 6); m_deliver(8'h22);
        bus_read(A_ST, exp_status(1'b1, 1'b0), "status_overrun");
        read_rx("rxdata_overrun");
        idle(2);
        chk("irq_overrun_held", 32'(irq), 32'(m_valid | m_ovr));
        bus_write(A_ST, 32'h8); m_ovr = 1'b0;
        idle(2);
        chk("irq_after_clear", 32'(irq), 32'(m_valid | m_ovr));
        bus_read(A_ST, exp_status(1'b1, 1'b0), "status_after_clear");

        // Glitch and framing error
        rx = 1'b0; idle(2); rx = 1'b1; idle(30);
        bus_read(A_ST, exp_status(1'b1, 1'b0), "status_glitch");
        rx_frame(8'h55, 1'b0); idle(tb_div + 6);
        bus_read(A_ST, exp_status(1'b1, 1'b0), "status_framing");
        chk("irq_framing", 32'(irq), 32'(m_valid | m_ovr));

        // Random RX, one or two frames per read
        for (int r = 0; r < 6; r++) begin
            int nf;
            logic [7:0] b;
            write_div($urandom_range(2, 10));
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                b = 8'($urandom);
                rx_frame(b, 1'b1); idle(tb_div + 6); m_deliver(b);
            end
            chk("irq_rand_rx", 32'(irq), 32'(m_valid | m_ovr));
            bus_read(A_ST, exp_status(1'b1, 1'b0), "status_rand_rx");
            read_rx("rxdata_rand");
            if (m_ovr) begin bus_write(A_ST, 32'h8); m_ovr = 1'b0; end
            idle(3);
            chk("irq_rand_clear", 32'(irq), 32'(m_valid | m_ovr));
        end

        // DIV clamp
        write_div(1);
        bus_read(A_DIV, 32'(tb_div), "div_clamp_1");
        write_div(0);
        bus_read(A_DIV, 32'(tb_div), "div_clamp_0");

        // Reset mid-frame
        write_div(4);
        bus_write(A_TX, 32'h5A);
        idle(12);
        rst_n = 1'b0;
        @(negedge clk);
        chk("tx_reset_abort", 32'(tx), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; tb_div = 434; m_valid = 1'b0; m_ovr = 1'b0; m_byte = '0;
        @(negedge clk);
        chk("irq_after_reset", 32'(irq), 32'd0);
        bus_read(A_ST, exp_status(1'b1, 1'b0), "status_after_reset");
        bus_read(A_DIV, 32'd434, "div_after_reset");
        idle(60);

        chk("tx_queue_empty", 32'(tx_exp_q.size()), 32'd0);
        chk("rd_queue_empty", 32'(rd_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_device.md
Name: uart_device

Overview:
- Memory-mapped UART slave attached to one device port of the system bus; consumes device_req/addr/we/wdata and returns device_rdata.
- 8N1 serial TX with a small transmit FIFO.
- 8N1 serial RX with a single holding register.
- Programmable baud divider and a level interrupt for received data.

Parameters:
- DataWidth, 32, bus data width; only bits [7:0] carry UART data.
- AddrressWidth, 32, bus address width; only addr[3:2] is decoded.
- TxFifoDepth, 8, TX FIFO entries; must be a power of two, at least 2.
- DivWidth, 16, width of the baud divider register.
- DefaultDiv, 434, reset divider value in clock cycles per bit (50 MHz / 115200).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset; one clock; reset is synchronous and active-low
- device_req_i  input  1  bus request for this device
- device_addr_i  input  AddrressWidth  byte address; [3:2] selects the register
- device_we_i  input  1  1 = write, 0 = read
- device_wdata_i  input  DataWidth  write data
- device_rdata_o  output  DataWidth  registered read data
- uart_tx_o  output  1  serial out; idle high
- uart_rx_i  input  1  serial in; asynchronous
- irq_o  output  1  registered interrupt = rx_valid | rx_overrun

Behaviour:
- Register map by addr[3:2]:
  - 0 TXDATA: write pushes wdata[7:0]; read returns 0.
  - 1 RXDATA: read returns {rx_valid, 23'b0, rx_byte}; pops the byte when rx_valid = 1.
  - 2 STATUS: read {28'b0, rx_overrun, rx_valid, tx_empty, tx_full}; writing 1 to bit 3 clears rx_overrun.
  - 3 DIV: read/write [DivWidth-1:0].
- Bus handshake:
  - Every request completes in one cycle; there is no stall.
  - Read data appears on device_rdata_o in the cycle after the req&~we cycle and holds until the next read.
  - Writes never change device_rdata_o.
  - Side effects (push, pop, clear) occur only in the cycle where device_req_i = 1.
- Reset values:
  - device_rdata_o = 0, uart_tx_o = 1, irq_o = 0.
  - FIFO empty, rx_valid = 0, rx_overrun = 0, DIV = DefaultDiv.
  - Both FSMs return to IDLE.
  - Reset asserted mid-frame aborts the frame; uart_tx_o is 1 in the next cycle.
- DIV: written values below 2 are stored as 2. Bit period is DIV cycles.
- TX FIFO:
  - Push when full is dropped silently.
  - Push and pop in the same cycle while full: the push is accepted and the count is unchanged.
  - Pointers wrap modulo TxFifoDepth.
  - A count of width clog2(TxFifoDepth)+1 distinguishes full from empty.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with FIFO non-empty: pop the byte, go to START.
  - START drives 0 for DIV cycles.
  - DATA drives 8 bits LSB first, DIV cycles each.
  - STOP drives 1 for DIV cycles, then returns to IDLE, or goes straight to START if the FIFO is non-empty (back-to-back frames with no idle gap).
  - A DIV write mid-frame takes effect at the next bit boundary.
  - tx_empty = FIFO empty & FSM in IDLE.
- RX path:
  - uart_rx_i passes through a 2-flop synchronizer before use.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a falling edge (synced 1 then 0) goes to START.
  - START: wait DIV/2 cycles; if the line is still 0 go to DATA, otherwise return to IDLE (glitch rejected).
  - DATA: sample 8 bits, each at DIV cycles after the previous sample, LSB first.
  - STOP: sample after DIV cycles. Stop bit = 1 delivers the byte; stop bit = 0 is a framing error, the byte is discarded, no flag is set. Then return to IDLE.
- RX holding register:
  - Delivery with rx_valid = 0: load rx_byte, set rx_valid.
  - Delivery with rx_valid = 1: set rx_overrun; the old byte is kept and the new byte dropped.
  - Delivery in the same cycle as an RXDATA pop: load the new byte, rx_valid stays 1, no overrun.
- irq_o lags the flag state by one cycle.

Decomposition:
- Package uart_pkg holds:
  - register offsets TXDATA, RXDATA, STATUS, DIV (2-bit);
  - STATUS bit indices;
  - shared FSM state enum IDLE, START, DATA, STOP;
  - MinDiv = 2.
- One sub-module, uart_fifo: synchronous FIFO parameterized by width and depth, with push, pop, full, empty and count.
- Both FSMs and the register file live in uart_device.

Test Plan:
- Reset check: hold rst_ni = 0 for 3 cycles, release -> uart_tx_o = 1, irq_o = 0, STATUS read returns 0x2, DIV read returns 434.
- Single TX: write DIV = 4, write TXDATA = 0xA5 -> uart_tx_o shows 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; STATUS = 0x2 afterwards.
- FIFO full: with DIV = 4 and the first byte already popped, write 9 more bytes 0x01..0x09 -> tx_full = 1 after 8 pushes, 0x09 dropped; 9 contiguous frames 0x00(first),0x01..0x08 with no idle gap.
- RX with irq: DIV = 8, drive frame 0x3C on uart_rx_i -> irq_o = 1 about 2 cycles after the stop sample; RXDATA read returns 0x8000003C the next cycle; irq_o = 0 afterwards; a second read returns 0x00000000.
- Overrun: receive 0x11 then 0x22 without reading -> STATUS = 0xE, RXDATA = 0x80000011; write STATUS = 0x8 -> overrun cleared, irq_o drops once rx_valid is also 0.
- Glitch and framing: 2-cycle low pulse on uart_rx_i with DIV = 8 -> no byte delivered; frame with stop bit 0 -> rx_valid stays 0; DIV write of 1 -> reads back 2.
